// File: rtl/lsu_req_ctrl.sv
// Load/store request sequencer: buffers core requests in an in-order queue, issues them
// one at a time on the lsu single-cycle port and returns one tagged response per request.
module lsu_req_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic             rsp_err,
    output logic [15:0]      rsp_rdata,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             lsu_enable,
    output logic             lsu_mem_write,
    output logic [15:0]      lsu_addr,
    output logic [15:0]      lsu_wdata,
    input  logic [15:0]      lsu_rdata,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             write;
        logic [15:0]      addr;
        logic [15:0]      wdata;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state, state_d;
    req_t               q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_d;
    req_t               req_in, head, issue_ent;
    logic               push, pop, head_ok, issue_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_in   = {req_write, req_addr, req_wdata, req_tag};
    assign head     = q[rd_ptr];
    assign push     = req_valid && req_ready;
    assign pop      = (state == ISSUE);
    assign count_d  = count + CNT_W'(push) - CNT_W'(pop);
    assign head_ok  = (head.addr[15:8] == 8'h00);
    assign issue_ok = (issue_ent.addr[15:8] == 8'h00);

    // Next state; issue_ent is the entry that will sit at the queue head during the next ISSUE
    always_comb begin
        state_d   = state;
        issue_ent = head;
        case (state)
            IDLE:  if (count != '0) state_d = ISSUE;
            ISSUE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = (count_d != '0) ? ISSUE : IDLE;
                    if (count == '0) issue_ent = req_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= req_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_d;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
            rsp_tag       <= '0;
            lsu_enable    <= 1'b0;
            lsu_mem_write <= 1'b0;
            lsu_addr      <= '0;
            lsu_wdata     <= '0;
        end else begin
            state         <= state_d;
            req_ready     <= (count_d != CNT_W'(DEPTH));
            busy          <= (count_d != '0) || (state_d != IDLE);
            rsp_valid     <= (state_d == RESP);
            lsu_enable    <= 1'b0;
            lsu_mem_write <= 1'b0;
            lsu_addr      <= '0;
            lsu_wdata     <= '0;
            if (state_d == ISSUE && issue_ok) begin
                lsu_enable    <= 1'b1;
                lsu_mem_write <= issue_ent.write;
                lsu_addr      <= issue_ent.addr;
                lsu_wdata     <= issue_ent.wdata;
            end
            if (state == ISSUE) begin
                rsp_write <= head.write;
                rsp_err   <= !head_ok;
                rsp_rdata <= (head_ok && !head.write) ? lsu_rdata : 16'h0000;
                rsp_tag   <= head.tag;
            end
        end
    end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Directed bench for lsu_req_ctrl with a behavioural lsu memory and an in-order response scoreboard.
module tb_lsu_req_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 3;

    logic             clk;
    logic             reset;
    logic             req_valid, req_ready, req_write;
    logic [15:0]      req_addr, req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [15:0]      rsp_rdata;
    logic [TAG_W-1:0] rsp_tag;
    logic             lsu_enable, lsu_mem_write;
    logic [15:0]      lsu_addr, lsu_wdata, lsu_rdata;
    logic             busy;

    lsu_req_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
        .lsu_enable(lsu_enable), .lsu_mem_write(lsu_mem_write), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lsu: combinational read, write at the closing edge of an enabled store
    logic [15:0] mem_dut [256];
    logic        mem_clr, pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    assign lsu_rdata = mem_dut[lsu_addr[7:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_dut[i] <= 16'h0000;
        end else if (pre_en) begin
            mem_dut[pre_addr] <= pre_data;
        end else if (lsu_enable && lsu_mem_write) begin
            mem_dut[lsu_addr[7:0]] <= lsu_wdata;
        end
    end

    typedef struct {
        logic             write;
        logic             err;
        logic [15:0]      rdata;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [256];
    int          n_vec, n_err, cyc, last_rsp_cyc, acc;
    bit          stream_mode, will;
    logic [15:0] bp_addr [4] = '{16'h0012, 16'h0040, 16'h0000, 16'h0012};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Compare any presented response against the scoreboard head, then record new requests
    task automatic monitor();
        exp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb[0];
                chk("rsp_tag",   32'(rsp_tag),   32'(e.tag));
                chk("rsp_write", 32'(rsp_write), 32'(e.write));
                chk("rsp_err",   32'(rsp_err),   32'(e.err));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    if (stream_mode) begin
                        if (last_rsp_cyc >= 0) chk("rsp_spacing", 32'(cyc - last_rsp_cyc), 32'd2);
                        last_rsp_cyc = cyc;
                    end
                end
            end
        end
        if (req_valid && req_ready) begin
            e.write = req_write;
            e.tag   = req_tag;
            e.err   = (req_addr[15:8] != 8'h00);
            e.rdata = (e.err || req_write) ? 16'h0000 : ref_mem[req_addr[7:0]];
            if (req_write && !e.err) ref_mem[req_addr[7:0]] = req_wdata;
            sb.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [TAG_W-1:0] t);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_tag = t;
        for (int i = 0; i < 50; i++) begin
            ok = req_ready;
            cycle();
            if (ok) break;
        end
        if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) break;
            cycle();
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; last_rsp_cyc = -1; stream_mode = 1'b0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_tag = '0; rsp_ready = 1'b1;
        mem_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        pre_en = 1'b1; pre_addr = 8'h12; pre_data = 16'hBEEF; ref_mem[8'h12] = 16'hBEEF;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        reset = 1'b0;

        // Reset state
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_lsu_en",    32'(lsu_enable), 32'd0);
        chk("reset_rsp_tag",   32'(rsp_tag),   32'd0);

        // Single load, cycle-exact latency
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0012; req_tag = 3'd5;
        cycle();
        req_valid = 1'b0;
        chk("c1_lsu_en",   32'(lsu_enable), 32'd0);
        chk("c1_busy",     32'(busy),       32'd1);
        cycle();
        chk("c2_lsu_en",   32'(lsu_enable),    32'd1);
        chk("c2_lsu_wr",   32'(lsu_mem_write), 32'd0);
        chk("c2_lsu_addr", 32'(lsu_addr),      32'h12);
        chk("c2_rsp_vld",  32'(rsp_valid),     32'd0);
        cycle();
        chk("c3_rsp_vld",  32'(rsp_valid),     32'd1);
        chk("c3_rdata",    32'(rsp_rdata),     32'hBEEF);
        drain();

        // Store then load
        send(1'b1, 16'h0040, 16'hA5A5, 3'd3);
        send(1'b0, 16'h0040, 16'h0000, 3'd2);
        drain();

        // Out-of-range load never touches the lsu
        send(1'b1, 16'h0000, 16'h1234, 3'd1);
        drain();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100; req_tag = 3'd7;
        for (int i = 0; i < 6; i++) begin
            cycle();
            req_valid = 1'b0;
            chk("oor_lsu_en", 32'(lsu_enable), 32'd0);
        end
        drain();
        send(1'b0, 16'h0000, 16'h0000, 3'd6);
        drain();

        // Back-pressure until full, then release
        rsp_ready = 1'b0; acc = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = bp_addr[0]; req_tag = 3'd1;
        for (int c = 0; c < 10; c++) begin
            will = req_valid && req_ready;
            cycle();
            if (will) begin
                acc++;
                if (acc < 4) begin req_addr = bp_addr[acc]; req_tag = 3'(acc + 1); end
                else req_valid = 1'b0;
            end
        end
        chk("full_accepts",   32'(acc),       32'd3);
        chk("full_req_ready", 32'(req_ready), 32'd0);
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (acc == 4 && sb.size() == 0 && !busy) break;
            will = req_valid && req_ready;
            cycle();
            if (will) begin acc++; req_valid = 1'b0; end
        end
        chk("bp_total_accepts", 32'(acc), 32'd4);
        drain();

        // Streaming stores, one response every 2 cycles
        stream_mode = 1'b1; last_rsp_cyc = -1; acc = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0000; req_wdata = 16'h1000; req_tag = 3'd0;
        for (int c = 0; c < 80; c++) begin
            if (acc == 8 && sb.size() == 0 && !busy) break;
            will = req_valid && req_ready;
            cycle();
            if (will) begin
                acc++;
                if (acc < 8) begin
                    req_addr = 16'(acc); req_wdata = 16'h1000 + 16'(acc); req_tag = 3'(acc);
                end else req_valid = 1'b0;
            end
        end
        chk("stream_accepts", 32'(acc), 32'd8);
        drain();
        stream_mode = 1'b0;
        req_write = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 16'(i), 16'h0000, 3'(i));
        drain();

        // Reset asserted while a store is in ISSUE with a load queued behind it
        send(1'b1, 16'h0030, 16'h5555, 3'd5);
        send(1'b0, 16'h0031, 16'h0000, 3'd6);
        for (int i = 0; i < 10; i++) begin
            if (lsu_enable && lsu_mem_write) break;
            cycle();
        end
        chk("rst_store_in_issue", 32'(lsu_enable && lsu_mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_lsu_en",    32'(lsu_enable),    32'd0);
        chk("rst_lsu_wr",    32'(lsu_mem_write), 32'd0);
        chk("rst_lsu_addr",  32'(lsu_addr),      32'd0);
        chk("rst_lsu_wdata", 32'(lsu_wdata),     32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),     32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata),     32'd0);
        chk("rst_rsp_tag",   32'(rsp_tag),       32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_req_ready", 32'(req_ready),     32'd1);
        sb.delete();
        ref_mem[8'h30] = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
            cycle();
        end
        send(1'b0, 16'h0030, 16'h0000, 3'd4);
        drain();

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
